// File: rtl/nsdp_pkg.sv
// Shared constants, header field positions, error bit indices and FSM states
// for the NSDP stream checker.
package nsdp_pkg;
    localparam logic [31:0] NSDP_MAGIC = 32'h4E53_4450;
    localparam int LANES     = 16;
    localparam int MAGIC_LSB = 480;
    localparam int SEQ_LSB   = 464;
    localparam int FC_LSB    = 432;
    localparam int TADDR_LSB = 368;

    localparam int ERR_LANE_LSB = 0;
    localparam int ERR_HDR      = 16;
    localparam int ERR_MAGIC    = 17;

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DRAIN, HALT} state_e;
endpackage

// File: rtl/nsdp_lane_compare.sv
// Combinational compare of every 32-bit lane of a beat against one value.
module nsdp_lane_compare
    import nsdp_pkg::*;
(
    input  logic [511:0]     beat,
    input  logic [31:0]      value,
    output logic [LANES-1:0] mismatch
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign mismatch[i] = (beat[i*32 +: 32] != value);
    end
endmodule

// File: rtl/nsdp_stream_checker.sv
// Sink-side NSDP checker: validates header fields and payload pattern of each
// packet and freezes a snapshot of the first failing beat.
module nsdp_stream_checker
    import nsdp_pkg::*;
#(
    parameter int unsigned DATA_BEATS  = 32,
    parameter logic [63:0] TADDR_BASE  = 64'h0,
    parameter logic [63:0] FRAME_BYTES = 64'h40_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [511:0] axis_in_tdata,
    input  logic         axis_in_tvalid,
    input  logic         axis_in_tlast,
    output logic         axis_in_tready,
    output logic         run_status,
    output logic [17:0]  error,
    output logic [511:0] error_data,
    output logic [31:0]  expected_fdata,
    output logic [63:0]  expected_taddr,
    output logic [31:0]  expected_fc,
    output logic [15:0]  expected_seq,
    output logic [63:0]  packets_rcvd,
    output logic [63:0]  malformed_packets
);
    localparam logic [63:0] BEAT_BYTES = 64'(DATA_BEATS) * 64'd64;
    localparam logic [63:0] FRAME_END  = TADDR_BASE + FRAME_BYTES;
    localparam logic [15:0] LAST_IDX   = 16'(DATA_BEATS - 1);

    state_e         state_q, state_d;
    logic           in_flight_q, in_flight_d;
    logic [15:0]    idx_q, idx_d;
    logic           run_q, run_d;
    logic [17:0]    err_q, err_d;
    logic [511:0]   edata_q, edata_d;
    logic [31:0]    fdata_q, fdata_d;
    logic [63:0]    taddr_q, taddr_d;
    logic [31:0]    fc_q, fc_d;
    logic [15:0]    seq_q, seq_d;
    logic [63:0]    pkts_q, pkts_d;
    logic [63:0]    malf_q, malf_d;

    logic [LANES-1:0] lane_bad;
    logic [31:0]      beat_fdata;
    logic [63:0]      taddr_inc;
    logic             magic_bad, field_bad;

    // The block never backpressures; ready simply follows reset.
    assign axis_in_tready = resetn;

    assign beat_fdata = fdata_q + 32'(idx_q);
    assign taddr_inc  = taddr_q + BEAT_BYTES;
    assign magic_bad  = axis_in_tdata[MAGIC_LSB +: 32] != NSDP_MAGIC;
    assign field_bad  = (axis_in_tdata[SEQ_LSB +: 16]   != seq_q) ||
                        (axis_in_tdata[FC_LSB +: 32]    != fc_q)  ||
                        (axis_in_tdata[TADDR_LSB +: 64] != taddr_q);

    nsdp_lane_compare u_cmp (
        .beat     (axis_in_tdata),
        .value    (beat_fdata),
        .mismatch (lane_bad)
    );

    always_comb begin
        state_d     = state_q;
        in_flight_d = in_flight_q;
        idx_d       = idx_q;
        run_d       = run_q;
        err_d       = err_q;
        edata_d     = edata_q;
        fdata_d     = fdata_q;
        taddr_d     = taddr_q;
        fc_d        = fc_q;
        seq_d       = seq_q;
        pkts_d      = pkts_q;
        malf_d      = malf_q;

        if (axis_in_tvalid) in_flight_d = !axis_in_tlast;

        if (start) begin
            // A beat arriving with start is not checked; it only moves in_flight.
            state_d = in_flight_d ? DRAIN : HEADER;
            idx_d   = '0;
            run_d   = 1'b1;
            err_d   = '0;
            edata_d = '0;
            fdata_d = '0;
            taddr_d = TADDR_BASE;
            fc_d    = '0;
            seq_d   = '0;
            pkts_d  = '0;
            malf_d  = '0;
        end else if (axis_in_tvalid) begin
            unique case (state_q)
                HEADER: begin
                    if (axis_in_tlast) begin
                        malf_d = malf_q + 64'd1;
                    end else if (magic_bad || field_bad) begin
                        state_d           = HALT;
                        err_d[ERR_MAGIC]  = magic_bad;
                        err_d[ERR_HDR]    = field_bad;
                        edata_d           = axis_in_tdata;
                        run_d             = 1'b0;
                    end else begin
                        state_d = PAYLOAD;
                        idx_d   = '0;
                    end
                end
                PAYLOAD: begin
                    if (|lane_bad) begin
                        state_d = HALT;
                        err_d[ERR_LANE_LSB +: LANES] = lane_bad;
                        edata_d = axis_in_tdata;
                        run_d   = 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        if (axis_in_tlast) begin
                            state_d = HEADER;
                            pkts_d  = pkts_q + 64'd1;
                            seq_d   = seq_q + 16'd1;
                            fdata_d = fdata_q + 32'(DATA_BEATS);
                            if (taddr_inc >= FRAME_END) begin
                                taddr_d = TADDR_BASE;
                                fc_d    = fc_q + 32'd1;
                            end else begin
                                taddr_d = taddr_inc;
                            end
                        end else begin
                            state_d = DRAIN;
                            malf_d  = malf_q + 64'd1;
                        end
                    end else if (axis_in_tlast) begin
                        state_d = HEADER;
                        malf_d  = malf_q + 64'd1;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
                DRAIN: if (axis_in_tlast) state_d = HEADER;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            in_flight_q <= 1'b0;
            idx_q       <= '0;
            run_q       <= 1'b0;
            err_q       <= '0;
            edata_q     <= '0;
            fdata_q     <= '0;
            taddr_q     <= '0;
            fc_q        <= '0;
            seq_q       <= '0;
            pkts_q      <= '0;
            malf_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            err_q       <= err_d;
            edata_q     <= edata_d;
            fdata_q     <= fdata_d;
            taddr_q     <= taddr_d;
            fc_q        <= fc_d;
            seq_q       <= seq_d;
            pkts_q      <= pkts_d;
            malf_q      <= malf_d;
        end
    end

    assign run_status        = run_q;
    assign error             = err_q;
    assign error_data        = edata_q;
    assign expected_fdata    = fdata_q;
    assign expected_taddr    = taddr_q;
    assign expected_fc       = fc_q;
    assign expected_seq      = seq_q;
    assign packets_rcvd      = pkts_q;
    assign malformed_packets = malf_q;
endmodule
